// File: rtl/addr_resilient_pipe.sv
// ---------------------------------------------------------------------------
// addr_resilient_pipe
//   Chunked, pipelined carry-propagate adder with optional redundant datapath
//   copies (single, duplicate-and-compare, triple with majority vote).
//   Each pipeline stage adds CHUNK operand bits plus the carry registered by
//   the previous stage.  The final stage is the output register.  The result
//   therefore appears STAGES cycles after the operands are accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready  block accepts operands
//   a, b, cin  unsigned operands and carry-in
//   fi_en      fault-injection enable  fi_mask   XOR mask for copy B result
//   clr_count  clear the error counter
//   out_valid  result valid            out_ready consumer accepts result
//   sum        WIDTH+1 bit result, MSB is carry-out
//   err        redundant copies disagree on the presented result
//   err_count  saturating count of transferred erroneous results
// ---------------------------------------------------------------------------
module addr_resilient_pipe #(
    parameter int WIDTH  = 8,
    parameter int CHUNK  = 4,
    parameter int MODE   = 1,
    parameter int ECNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              fi_en,
    input  logic [WIDTH:0]    fi_mask,
    input  logic              clr_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    sum,
    output logic              err,
    output logic [ECNT_W-1:0] err_count
);

    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam int NCOPY  = (MODE == 0) ? 1 : ((MODE == 1) ? 2 : 3);

    function automatic logic [WIDTH:0] inject(input logic [WIDTH:0] r,
                                              input logic           en,
                                              input logic [WIDTH:0] m);
        return en ? (r ^ m) : r;
    endfunction

    function automatic logic [WIDTH:0] majority(input logic [WIDTH:0] x,
                                                input logic [WIDTH:0] y,
                                                input logic [WIDTH:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // One global advance: the whole pipe moves when the output register is
    // empty or being drained, otherwise every stage holds.
    logic [STAGES-1:0] vld_p;
    logic              adv;
    logic              in_fire;
    logic              out_fire;
    logic [WIDTH:0]    voted;
    logic              mis;

    assign adv       = !vld_p[LAST] || out_ready;
    assign in_ready  = adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld_p[LAST];
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else if (adv) begin
            vld_p[0] <= in_fire;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Independent datapath copies; each declares its own stage registers so
    // nothing is shared between copies.
    for (genvar c = 0; c < NCOPY; c++) begin : g_cp
        for (genvar k = 0; k < STAGES; k++) begin : g_st
            localparam int LO = k * CHUNK;
            localparam int CW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;
            localparam int HI = LO + CW;

            // ai/bi: operand bits not yet consumed; sn: finished sum bits
            logic [WIDTH-LO-1:0] ai;
            logic [WIDTH-LO-1:0] bi;
            logic                ci;
            logic [CW:0]         t;
            logic [HI-1:0]       sn;

            if (k == 0) begin : g_src
                assign ai = a;
                assign bi = b;
                assign ci = cin;
                assign sn = t[CW-1:0];
            end else begin : g_src
                assign ai = g_st[k-1].g_reg.a_q;
                assign bi = g_st[k-1].g_reg.b_q;
                assign ci = g_st[k-1].g_reg.c_q;
                assign sn = {t[CW-1:0], g_st[k-1].g_reg.s_q};
            end

            assign t = {1'b0, ai[CW-1:0]} + {1'b0, bi[CW-1:0]} + {{CW{1'b0}}, ci};

            if (k < LAST) begin : g_reg
                // ---- stage k register: remaining operands, partial sum, carry
                logic [WIDTH-HI-1:0] a_q;
                logic [WIDTH-HI-1:0] b_q;
                logic [HI-1:0]       s_q;
                logic                c_q;

                always_ff @(posedge clk) begin
                    if (adv) begin
                        a_q <= ai[WIDTH-LO-1:CW];
                        b_q <= bi[WIDTH-LO-1:CW];
                        s_q <= sn;
                        c_q <= t[CW];
                    end
                end
            end else begin : g_out
                // ---- output register: final chunk, carry-out, fault point
                logic [WIDTH:0] res_q;
                logic           ld;

                assign ld = (k == 0) ? in_fire : vld_p[(k == 0) ? 0 : k - 1];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        res_q <= '0;
                    end else if (adv && ld) begin
                        res_q <= inject({t[CW], sn}, (c == 1) && fi_en, fi_mask);
                    end
                end
            end
        end
    end

    if (MODE == 0) begin : g_vote
        assign voted = g_cp[0].g_st[LAST].g_out.res_q;
        assign mis   = 1'b0;
    end else if (MODE == 1) begin : g_vote
        logic [WIDTH:0] ra;
        logic [WIDTH:0] rb;
        assign ra    = g_cp[0].g_st[LAST].g_out.res_q;
        assign rb    = g_cp[1].g_st[LAST].g_out.res_q;
        assign voted = ra;
        assign mis   = (ra != rb);
    end else begin : g_vote
        logic [WIDTH:0] ra;
        logic [WIDTH:0] rb;
        logic [WIDTH:0] rc;
        assign ra    = g_cp[0].g_st[LAST].g_out.res_q;
        assign rb    = g_cp[1].g_st[LAST].g_out.res_q;
        assign rc    = g_cp[2].g_st[LAST].g_out.res_q;
        assign voted = majority(ra, rb, rc);
        assign mis   = (ra != voted) || (rb != voted) || (rc != voted);
    end

    assign sum = voted;
    assign err = out_valid && mis;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            err_count <= '0;
        end else if (out_fire && err) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_addr_resilient_pipe.sv
module tb_addr_resilient_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       fi_en;
    logic [8:0] fi_mask;
    logic       clr_count;
    logic       out_ready;

    logic       in_ready1, out_valid1, err1;
    logic [8:0] sum1;
    logic [7:0] cnt1;
    logic       in_ready2, out_valid2, err2;
    logic [8:0] sum2;
    logic [7:0] cnt2;
    logic       in_ready3, out_valid3, err3;
    logic [8:0] sum3;
    logic [1:0] cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    addr_resilient_pipe #(.WIDTH(8), .CHUNK(4), .MODE(1), .ECNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .fi_en(fi_en), .fi_mask(fi_mask),
        .clr_count(clr_count), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .err(err1), .err_count(cnt1));

    addr_resilient_pipe #(.WIDTH(8), .CHUNK(4), .MODE(2), .ECNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .fi_en(fi_en), .fi_mask(fi_mask),
        .clr_count(clr_count), .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .err(err2), .err_count(cnt2));

    addr_resilient_pipe #(.WIDTH(8), .CHUNK(4), .MODE(1), .ECNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .a(a), .b(b), .cin(cin), .fi_en(fi_en), .fi_mask(fi_mask),
        .clr_count(clr_count), .out_valid(out_valid3), .out_ready(out_ready),
        .sum(sum3), .err(err3), .err_count(cnt3));

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b want 0", out_valid1); end
        n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid2: got %b want 0", out_valid2); end
        n_tests++; if (sum1 !== 9'h000) begin n_fail++; $display("FAIL reset_sum1: got %h want 000", sum1); end
        n_tests++; if (sum2 !== 9'h000) begin n_fail++; $display("FAIL reset_sum2: got %h want 000", sum2); end
        n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL reset_err1: got %b want 0", err1); end
        n_tests++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
        n_tests++; if (cnt3 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt3: got %0d want 0", cnt3); end
        n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready1: got %b want 1", in_ready1); end
        rst = 1'b0; in_valid = 1'b0;
        // operands offered during the reset cycles must never emerge
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_drop_input cyc %0d: got %b want 0", i, out_valid1); end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", out_valid1); end
        @(negedge clk);
        n_tests++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", out_valid1); end
        n_tests++; if (sum1 !== 9'h100) begin n_fail++; $display("FAIL latency_sum1: got %h want 100", sum1); end
        n_tests++; if (sum2 !== 9'h100) begin n_fail++; $display("FAIL latency_sum2: got %h want 100", sum2); end
        n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL latency_err1: got %b want 0", err1); end
        n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL latency_err2: got %b want 0", err2); end
        @(negedge clk);
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL latency_single: got %b want 0", out_valid1); end
    endtask

    task automatic test_stream();
        int rcv = 0;
        logic exp_v;
        for (int cyc = 0; cyc < 259; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (cyc < 256);
            a   = 8'(cyc);
            b   = 8'(255 - cyc);
            cin = 1'b1;
            #1;
            exp_v = (cyc >= 2) && (cyc <= 257);
            n_tests++; if (out_valid1 !== exp_v) begin n_fail++; $display("FAIL stream_valid cyc %0d: got %b want %b", cyc, out_valid1, exp_v); end
            if (out_valid1 === 1'b1) begin
                rcv++;
                n_tests++; if (sum1 !== 9'h100) begin n_fail++; $display("FAIL stream_sum cyc %0d: got %h want 100", cyc, sum1); end
            end
        end
        in_valid = 1'b0;
        n_tests++; if (rcv !== 256) begin n_fail++; $display("FAIL stream_count: got %0d want 256", rcv); end
    endtask

    task automatic test_stall();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [8:0] te [3];
        int idx = 0;
        int rcv = 0;
        ta[0] = 8'h10; tb[0] = 8'h05; tc[0] = 1'b0; te[0] = 9'h015;
        ta[1] = 8'h20; tb[1] = 8'hF0; tc[1] = 1'b1; te[1] = 9'h111;
        ta[2] = 8'h80; tb[2] = 8'h90; tc[2] = 1'b0; te[2] = 9'h110;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 6);
            in_valid  = (idx < 3);
            if (idx < 3) begin
                a = ta[idx]; b = tb[idx]; cin = tc[idx];
            end
            #1;
            if (out_valid1 === 1'b1) begin
                n_tests++; if (in_ready1 !== out_ready) begin n_fail++; $display("FAIL stall_in_ready cyc %0d: got %b want %b", cyc, in_ready1, out_ready); end
            end
            if (out_valid1 === 1'b1 && out_ready) begin
                if (rcv < 3) begin
                    n_tests++; if (sum1 !== te[rcv]) begin n_fail++; $display("FAIL stall_order1 item %0d: got %h want %h", rcv, sum1, te[rcv]); end
                    n_tests++; if (sum2 !== te[rcv]) begin n_fail++; $display("FAIL stall_order2 item %0d: got %h want %h", rcv, sum2, te[rcv]); end
                end
                rcv++;
            end
            if (in_valid && in_ready1 === 1'b1) idx++;
        end
        in_valid = 1'b0;
        n_tests++; if (rcv !== 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", rcv); end
    endtask

    task automatic test_fault();
        @(negedge clk);
        clr_count = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 8'd3; b = 8'd4; cin = 1'b0;
        fi_en = 1'b1; fi_mask = 9'h001;
        @(negedge clk);
        clr_count = 1'b0; in_valid = 1'b0;
        n_tests++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL fault_cnt_before: got %0d want 0", cnt1); end
        @(negedge clk);
        n_tests++; if (sum1 !== 9'h007) begin n_fail++; $display("FAIL fault_sum_m1: got %h want 007", sum1); end
        n_tests++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL fault_err_m1: got %b want 1", err1); end
        n_tests++; if (sum2 !== 9'h007) begin n_fail++; $display("FAIL fault_sum_m2: got %h want 007", sum2); end
        n_tests++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL fault_err_m2: got %b want 1", err2); end
        @(negedge clk);
        n_tests++; if (cnt1 !== 8'd1) begin n_fail++; $display("FAIL fault_cnt_m1: got %0d want 1", cnt1); end
        n_tests++; if (cnt2 !== 8'd1) begin n_fail++; $display("FAIL fault_cnt_m2: got %0d want 1", cnt2); end
        n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL fault_err_idle: got %b want 0", err1); end
        // a zero mask must leave the copies in agreement
        fi_mask = 9'h000; in_valid = 1'b1; a = 8'h55; b = 8'hAA; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (sum1 !== 9'h100) begin n_fail++; $display("FAIL fault_zero_mask_sum: got %h want 100", sum1); end
        n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL fault_zero_mask_err: got %b want 0", err1); end
        @(negedge clk);
        fi_en = 1'b0;
        n_tests++; if (cnt1 !== 8'd1) begin n_fail++; $display("FAIL fault_zero_mask_cnt: got %0d want 1", cnt1); end
    endtask

    task automatic test_saturate();
        logic [1:0] ec [8];
        ec[3] = 2'd1; ec[4] = 2'd2; ec[5] = 2'd3; ec[6] = 2'd3; ec[7] = 2'd0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) begin
                n_tests++; if (cnt3 !== ec[cyc]) begin n_fail++; $display("FAIL sat_cnt cyc %0d: got %0d want %0d", cyc, cnt3, ec[cyc]); end
            end
            if (cyc == 6) begin
                n_tests++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL sat_fifth_err: got %b want 1", err3); end
            end
            out_ready = 1'b1;
            fi_en = 1'b1; fi_mask = 9'h001;
            in_valid = (cyc < 5); a = 8'(cyc); b = 8'd1; cin = 1'b0;
            clr_count = (cyc == 0) || (cyc == 6);
        end
        clr_count = 1'b0; fi_en = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b1; fi_en = 1'b1; fi_mask = 9'h001;
        in_valid = 1'b1; a = 8'd1; b = 8'd1; cin = 1'b0;
        @(negedge clk);
        a = 8'd2; b = 8'd2;
        @(negedge clk);
        a = 8'd3; b = 8'd3;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++; if (cnt1 !== 8'd1) begin n_fail++; $display("FAIL rstmid_cnt_pre: got %0d want 1", cnt1); end
        n_tests++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight: got %b want 1", out_valid1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; fi_en = 1'b0;
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid1: got %b want 0", out_valid1); end
        n_tests++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid2: got %b want 0", out_valid2); end
        n_tests++; if (cnt1 !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", cnt1); end
        n_tests++; if (sum1 !== 9'h000) begin n_fail++; $display("FAIL rstmid_sum: got %h want 000", sum1); end
        n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready1); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard cyc %0d: got %b want 0", i, out_valid1); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        fi_en = 1'b0; fi_mask = '0; clr_count = 1'b0; out_ready = 1'b1;
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_fault();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/addr_resilient_pipe.md
ADDR_RESILIENT_PIPE -- requirements
Module: addr_resilient_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..64.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage, 1..WIDTH; STAGES = ceil(WIDTH/CHUNK).
REQ-003 SHALL have parameter MODE, default 1: redundancy mode; 0 = single adder, 1 = duplicate-and-compare, 2 = triple with bitwise majority vote.
REQ-004 SHALL have parameter ECNT_W, default 8: error counter width.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  operands valid.
REQ-008 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-009 SHALL have ports a, b  input  WIDTH each  unsigned operands; cin input 1 carry-in.
REQ-010 SHALL have port fi_en  input  1  fault-injection enable (test only).
REQ-011 SHALL have port fi_mask  input  WIDTH+1  XOR mask applied to copy B final result when fi_en=1 at output-stage load.
REQ-012 SHALL have port clr_count  input  1  clears err_count.
REQ-013 SHALL have port out_valid  output  1  result valid; out_ready input 1 consumer accepts.
REQ-014 SHALL have port sum  output  WIDTH+1  result, MSB = carry-out.
REQ-015 SHALL have port err  output  1  redundancy mismatch on the presented result.
REQ-016 SHALL have port err_count  output  ECNT_W  saturating count of transferred erroneous results.

Function
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready); on stall every stage SHALL hold its contents.
REQ-019 Stage k (0-based) SHALL add operand bits [k*CHUNK +: CHUNK] (last chunk truncated to WIDTH) plus the registered carry from stage k-1 (cin for stage 0), forwarding remaining operand bits and finished sum bits.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent stalls; throughput one result per cycle.
REQ-021 Each stage SHALL carry its own valid bit; bubbles SHALL propagate, not collapse.
REQ-022 sum SHALL equal (a + b + cin) modulo 2^(WIDTH+1), computed fully at WIDTH+1 bits, no saturation.
REQ-023 MODE 0: one datapath; err SHALL be constant 0; fi_en/fi_mask ignored.
REQ-024 MODE 1: two independent datapath copies A, B; sum SHALL be copy A; err SHALL be 1 iff A != B.
REQ-025 MODE 2: copies A, B, C; sum SHALL be bitwise majority; err SHALL be 1 iff any copy differs from the voted value.
REQ-026 Fault injection SHALL XOR fi_mask into copy B when the result enters the output register; fi_mask=0 SHALL have no effect.
REQ-027 err SHALL be 0 whenever out_valid=0.
REQ-028 err_count SHALL increment by 1 on each output transfer with err=1, saturating at 2^ECNT_W-1.
REQ-029 clr_count SHALL set err_count to 0 next cycle; clr_count coincident with an increment SHALL win (result 0).
REQ-030 Redundant copies SHALL NOT share logic or registers so that synthesis keeps them distinct.

Reset
REQ-031 With rst=1 at a clock edge all stage valids, out_valid, sum, err and err_count SHALL be 0 next cycle; in_ready SHALL be 1 after reset.
REQ-032 rst mid-operation SHALL discard all in-flight results with no output transfer; input offered during the reset cycle SHALL be dropped.

Verification
REQ-033 WIDTH=8, CHUNK=4, MODE=1: a=0xFF, b=0x01, cin=0 -> out_valid exactly 2 cycles later, sum=0x100, err=0.
REQ-034 Stream a=0..255, b=255-a, cin=1, out_ready=1 -> 256 consecutive results sum=0x100, one per cycle, in order.
REQ-035 out_ready=0 for 5 cycles with 3 results in flight -> in_ready=0 while out_valid, no loss or duplication, order preserved after release.
REQ-036 MODE=1, fi_en=1, fi_mask=0x001, a=3, b=4 -> sum=0x007, err=1, err_count 0->1; MODE=2 same stimulus -> sum=0x007, err=1.
REQ-037 ECNT_W=2, four faulted transfers -> err_count 1,2,3,3; clr_count asserted with fifth faulted transfer -> err_count=0.
REQ-038 rst asserted with 2 results in flight -> out_valid=0 next cycle, no transfer of those results, err_count=0.
